mp3_data_array_ctrl: RTL and testbench
======================================

Name: mp3_data_array_ctrl

Overview:
- Initiator-side controller for the 32x128 single-port byte-masked data array SRAM used by the mp4 cache.
- Upstream side: valid/ready request channel and valid/ready read-response channel.
- Downstream side: drives the SRAM csb0/web0/wmask0/addr0/din0 port and captures dout0 at the correct edge.
- After reset, sweeps the whole array to a known value before accepting any traffic.

Parameters:
- ADDR_WIDTH, 5, SRAM word address width; depth = 1<<ADDR_WIDTH.
- DATA_WIDTH, 128, word width in bits.
- NUM_WMASKS, DATA_WIDTH/8, byte write-mask width.
- INIT_VALUE, 128'h0, word written to every entry during the init sweep.
- RSP_DEPTH, 2, response buffer entries. Legal values are 2..4.

Ports:
- clk  in  1  single clock; the SRAM clk0 is tied to this clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready at posedge.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wmask  in  NUM_WMASKS  byte enables for writes; ignored for reads.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts rsp_rdata.
- rsp_rdata  out  DATA_WIDTH  read data, in request order.
- init_done  out  1  high once the init sweep is complete.
- sram_csb0  out  1  active-low chip select.
- sram_web0  out  1  active-low write enable.
- sram_wmask0  out  NUM_WMASKS  byte mask.
- sram_addr0  out  ADDR_WIDTH  address.
- sram_din0  out  DATA_WIDTH  write data.
- sram_dout0  in  DATA_WIDTH  SRAM read data.

Behaviour:
- SRAM timing contract:
  - The SRAM samples its port at posedge E.
  - It performs the write or read at the following negedge.
  - dout0 is stable from that negedge until after posedge E+1.
  - The controller captures dout0 at posedge E+1 only.
- Port drive:
  - SRAM port outputs are combinational from the current state and the accepted request, so a request accepted at posedge E is presented to the SRAM at posedge E.
  - Idle drive: csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
- Reset (asynchronous, rst_n=0):
  - State=INIT, sweep counter=0, read_inflight=0, response buffer empty.
  - Outputs during reset: req_ready=0, rsp_valid=0, init_done=0, rsp_rdata=0, SRAM port in idle drive.
  - Asserting reset mid-operation discards in-flight reads and buffered responses, then restarts the sweep.
- FSM:
  - INIT: each cycle drives csb0=0, web0=0, wmask0=all ones, addr0=counter, din0=INIT_VALUE; counter increments.
    - After address depth-1 is issued, next state is RUN.
    - INIT lasts exactly 1<<ADDR_WIDTH cycles.
    - req_ready=0 throughout.
  - RUN: init_done=1 (registered, rises the cycle RUN is entered). There is no path back to INIT except reset.
- Writes in RUN:
  - req_ready=1 unconditionally.
  - Accepted write drives csb0=0, web0=0, wmask0=req_wmask, din0=req_wdata.
  - Writes produce no response.
  - req_wmask=0 still issues csb0=0 with no bytes changed.
- Reads in RUN:
  - req_ready = (occupancy + read_inflight - pop) < RSP_DEPTH, where pop = rsp_valid&&rsp_ready this cycle.
  - Accepted read drives csb0=0, web0=1, wmask0=0, and sets read_inflight for one cycle.
  - At the next posedge, dout0 is pushed into the buffer.
  - Latency: read accepted at posedge E gives rsp_valid=1 from posedge E+1.
  - Back-to-back reads at full throughput when rsp_ready is held high.
- Response buffer:
  - FIFO with RSP_DEPTH entries, wrapping pointers.
  - rsp_rdata is the head entry; rsp_valid = !empty.
  - Push and pop in the same cycle keep occupancy unchanged.
  - The buffer can never overflow by construction. The bench asserts no push when full.
- Ordering:
  - A read of address A accepted the cycle after a write to A returns the new data, because the write completes at the intervening negedge.
  - At most one request per cycle.

Optional Feature:
- Macro SRAM_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_rd_cnt[31:0] and perf_wr_cnt[31:0].
  - They count accepted RUN-state reads and writes; INIT writes are excluded.
  - Both wrap at 2^32 and reset to 0.
  - perf_stall_cnt[31:0] counts cycles with req_valid=1, req_write=0, req_ready=0 in RUN.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release -> exactly 32 cycles of csb0=0/web0=0/wmask0=16'hFFFF with addr 0..31 -> init_done=1 in cycle 33. Then read addr 7 -> rsp_rdata=128'h0.
- Write addr 3, wmask 16'h000F, wdata 128'h...DEADBEEF, then read addr 3 next cycle -> rsp_valid one cycle after read accept, rsp_rdata = 128'hDEADBEEF with upper 96 bits 0.
- rsp_ready=0, issue 3 reads (addr 1,2,3) -> first two accepted, third sees req_ready=0. Raise rsp_ready -> responses come out in order 1,2,3, with no loss or duplication.
- rsp_ready=1, 32 back-to-back reads after a full write pattern (word i = i replicated) -> 32 consecutive rsp_valid cycles, data i, zero stalls.
- Assert rst_n low for 1 cycle while 2 responses are buffered -> rsp_valid=0 immediately, init_done=0, sweep restarts at addr 0.
- With SRAM_CTRL_PERF_EN: 5 writes, 4 reads, 3 stall cycles -> perf_wr_cnt=5, perf_rd_cnt=4, perf_stall_cnt=3.

Source files
------------

// File: rtl/mp3_data_array_ctrl.sv
// Initiator-side controller for the mp4 cache 32x128 byte-masked data array SRAM.
// Optional performance counters are compiled in when SRAM_CTRL_PERF_EN is defined.
module mp3_data_array_ctrl #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 128,
    parameter int                    NUM_WMASKS = DATA_WIDTH / 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
`ifdef SRAM_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_rd_cnt,
    output logic [31:0]           perf_wr_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = 2;
    localparam int CNT_W = 3;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   sweep_cnt;
    logic                    read_inflight;
    logic [DATA_WIDTH-1:0]   buf_mem [0:3];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CNT_W-1:0]        count;
    logic [CNT_W:0]          pending;
    logic                    push;
    logic                    pop;
    logic                    accept;
    logic                    accept_read;
    logic                    read_room;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop         = rsp_valid && rsp_ready;
    assign push        = read_inflight;
    assign rsp_valid   = (count != '0);
    assign rsp_rdata   = rsp_valid ? buf_mem[head] : '0;
    assign init_done   = (state == RUN);

    // A read may only be accepted if its data is guaranteed a buffer slot next cycle.
    assign pending     = {1'b0, count} + (CNT_W+1)'(read_inflight) - (CNT_W+1)'(pop);
    assign read_room   = pending < (CNT_W+1)'(RSP_DEPTH);
    assign req_ready   = rst_n && (state == RUN) && (req_write || read_room);
    assign accept      = req_valid && req_ready;
    assign accept_read = accept && !req_write;

    always_comb begin
        state_next  = state;
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (rst_n) begin
            case (state)
                INIT: begin
                    sram_csb0   = 1'b0;
                    sram_web0   = 1'b0;
                    sram_wmask0 = '1;
                    sram_addr0  = sweep_cnt;
                    sram_din0   = INIT_VALUE;
                    if (sweep_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        sram_csb0  = 1'b0;
                        sram_web0  = !req_write;
                        sram_addr0 = req_addr;
                        if (req_write) begin
                            sram_wmask0 = req_wmask;
                            sram_din0   = req_wdata;
                        end
                    end
                end
                default: state_next = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT;
            sweep_cnt     <= '0;
            read_inflight <= 1'b0;
        end else begin
            state         <= state_next;
            read_inflight <= accept_read;
            if (state == INIT) begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end
    end

    // dout0 is only stable around the posedge following the read, so it is captured here.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[tail] <= sram_dout0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SRAM_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept_read) begin
                perf_rd_cnt <= perf_rd_cnt + 32'd1;
            end
            if (accept && req_write) begin
                perf_wr_cnt <= perf_wr_cnt + 32'd1;
            end
            if ((state == RUN) && req_valid && !req_write && !req_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mp3_data_array_ctrl.sv
// Scoreboard testbench for mp3_data_array_ctrl with a behavioural negedge-access SRAM.
// Performance counter checks are included when SRAM_CTRL_PERF_EN is defined.
module tb_mp3_data_array_ctrl;

    localparam int AW        = 5;
    localparam int DW        = 128;
    localparam int NW        = 16;
    localparam int RSP_DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [NW-1:0] req_wmask;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          sram_csb0;
    logic          sram_web0;
    logic [NW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;
`ifdef SRAM_CTRL_PERF_EN
    logic [31:0]   perf_rd_cnt;
    logic [31:0]   perf_wr_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    int            tests_run   = 0;
    int            fails       = 0;
    int            valid_cycles = 0;
    logic [DW-1:0] exp_q [$];

    mp3_data_array_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WMASKS (NW),
        .INIT_VALUE ('0),
        .RSP_DEPTH  (RSP_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wmask   (req_wmask),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .init_done   (init_done),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
`ifdef SRAM_CTRL_PERF_EN
        ,
        .perf_rd_cnt    (perf_rd_cnt),
        .perf_wr_cnt    (perf_wr_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // SRAM model: port sampled at posedge, access performed at the following negedge.
    logic [DW-1:0] sram_mem [32];
    logic          lat_csb = 1'b1;
    logic          lat_web = 1'b1;
    logic [NW-1:0] lat_wmask = '0;
    logic [AW-1:0] lat_addr = '0;
    logic [DW-1:0] lat_din = '0;

    initial begin
        for (int i = 0; i < 32; i++) sram_mem[i] = {4{32'hA5A5_5A5A}};
    end

    always @(posedge clk) begin
        lat_csb   <= sram_csb0;
        lat_web   <= sram_web0;
        lat_wmask <= sram_wmask0;
        lat_addr  <= sram_addr0;
        lat_din   <= sram_din0;
    end

    always @(negedge clk) begin
        if (!lat_csb) begin
            if (!lat_web) begin
                for (int b = 0; b < NW; b++)
                    if (lat_wmask[b]) sram_mem[lat_addr][b*8 +: 8] <= lat_din[b*8 +: 8];
            end else begin
                sram_dout0 <= sram_mem[lat_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake and watches for overflow.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                fails++;
                $display("[TB] FAIL rsp_unexpected: got %h, expected no response", rsp_rdata);
            end else begin
                checkOutput("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
        end
        if (rst_n && rsp_valid) valid_cycles++;
        if (rst_n && dut.read_inflight && dut.count == 3'(RSP_DEPTH) && !(rsp_valid && rsp_ready)) begin
            tests_run++;
            fails++;
            $display("[TB] FAIL buffer_overflow: got push into full buffer, expected none");
        end
    end

    // Drives one request at posedge+1 and holds it until accepted; reads queue their expected data.
    task automatic applyStimulus(input logic write, input logic [AW-1:0] addr,
                                 input logic [NW-1:0] wmask, input logic [DW-1:0] wdata,
                                 input logic [DW-1:0] expected, output int waited);
        logic accepted;
        accepted  = 1'b0;
        waited    = 0;
        req_valid = 1'b1;
        req_write = write;
        req_addr  = addr;
        req_wmask = wmask;
        req_wdata = wdata;
        while (!accepted) begin
            @(negedge clk);
            if (req_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
            if (!accepted) begin
                waited++;
                if (waited > 100) begin
                    tests_run++;
                    fails++;
                    $display("[TB] FAIL req_timeout: got no accept for addr %0d, expected accept", addr);
                    break;
                end
            end
        end
        if (accepted && !write) exp_q.push_back(expected);
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkInit();
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            checkOutput("init_sweep",
                        128'({sram_csb0, sram_web0, sram_wmask0, sram_addr0, req_ready, init_done}),
                        128'({1'b0, 1'b0, 16'hFFFF, 5'(k), 1'b0, 1'b0}));
        end
        @(negedge clk);
        checkOutput("init_done_rise", 128'(init_done), 128'(1'b1));
        checkOutput("run_idle_drive", 128'({sram_csb0, sram_web0, sram_wmask0, sram_addr0}),
                    128'({1'b1, 1'b1, 16'h0000, 5'd0}));
    endtask

    function automatic logic [DW-1:0] pattern(input int i);
        return {4{32'(i)}};
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int total_wait;
`ifdef SRAM_CTRL_PERF_EN
        logic [31:0] rd0, wr0, st0;
`endif
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wmask = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    128'({req_ready, rsp_valid, init_done, sram_csb0, sram_web0, sram_wmask0}),
                    128'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000}));
        checkOutput("reset_rdata", rsp_rdata, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        checkInit();
        idle(1);

        // Read after the init sweep sees the init value, not the preloaded garbage.
        applyStimulus(1'b0, 5'd7, '0, '0, '0, w);
        idle(3);

        // Masked write then immediate read of the same address, with latency check.
        applyStimulus(1'b1, 5'd3, 16'h000F, 128'h11112222_33334444_55556666_DEADBEEF, '0, w);
        applyStimulus(1'b0, 5'd3, '0, '0, 128'h00000000_00000000_00000000_DEADBEEF, w);
        @(negedge clk);
        checkOutput("rsp_latency_e", 128'(rsp_valid), 128'(1'b0));
        @(negedge clk);
        checkOutput("rsp_latency_e1", 128'(rsp_valid), 128'(1'b1));
        @(posedge clk);
        #1;
        idle(2);

        // Backpressure: third read stalls until the consumer drains.
        applyStimulus(1'b1, 5'd1, 16'hFFFF, 128'hA1, '0, w);
        applyStimulus(1'b1, 5'd2, 16'hFFFF, 128'hA2, '0, w);
        applyStimulus(1'b1, 5'd3, 16'hFFFF, 128'hA3, '0, w);
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 5'd1, '0, '0, 128'hA1, w);
        applyStimulus(1'b0, 5'd2, '0, '0, 128'hA2, w);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'd3;
        @(negedge clk);
        checkOutput("stall_ready", 128'(req_ready), 128'(1'b0));
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        applyStimulus(1'b0, 5'd3, '0, '0, 128'hA3, w);
        idle(4);
        checkOutput("drain_empty", 128'(exp_q.size()), 128'(0));

        // Full pattern then 32 back-to-back reads.
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 5'(i), 16'hFFFF, pattern(i), '0, w);
        valid_cycles = 0;
        total_wait   = 0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'(i), '0, '0, pattern(i), w);
            total_wait += w;
        end
        checkOutput("burst_stalls", 128'(total_wait), 128'(0));
        idle(4);
        checkOutput("burst_valid_cycles", 128'(valid_cycles), 128'(32));

        // Reset with two buffered responses.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 5'd5, '0, '0, pattern(5), w);
        applyStimulus(1'b0, 5'd6, '0, '0, pattern(6), w);
        idle(2);
        checkOutput("buffered_before_reset", 128'(rsp_valid), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_outputs",
                    128'({rsp_valid, init_done, req_ready, sram_csb0}),
                    128'({1'b0, 1'b0, 1'b0, 1'b1}));
        checkOutput("midreset_rdata", rsp_rdata, '0);
        exp_q.delete();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        checkInit();
        idle(1);
        applyStimulus(1'b0, 5'd5, '0, '0, '0, w);
        idle(3);

`ifdef SRAM_CTRL_PERF_EN
        rd0 = perf_rd_cnt;
        wr0 = perf_wr_cnt;
        st0 = perf_stall_cnt;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'(10 + i), 16'hFFFF, pattern(100 + i), '0, w);
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 5'd10, '0, '0, pattern(100), w);
        applyStimulus(1'b0, 5'd11, '0, '0, pattern(101), w);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'd12;
        idle(3);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        idle(3);
        applyStimulus(1'b0, 5'd12, '0, '0, pattern(102), w);
        applyStimulus(1'b0, 5'd13, '0, '0, pattern(103), w);
        idle(3);
        checkOutput("perf_wr_cnt", 128'(perf_wr_cnt - wr0), 128'(5));
        checkOutput("perf_rd_cnt", 128'(perf_rd_cnt - rd0), 128'(4));
        checkOutput("perf_stall_cnt", 128'(perf_stall_cnt - st0), 128'(3));
`endif

        idle(3);
        checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
